instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/fetch_slot.sv | 35 +++
 rtl/full_adder64.sv | 14 +
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared encodings for the fetch stage and its memory clients.
package instruction_fetch_pkg;

    typedef enum logic {
        StFetch = 1'b0,
        StHalt  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DefaultHaltWord = 32'd0;

    // Memory Status encoding shared by the Memory block and all its clients.
    localparam logic MemRead  = 1'b0;
    localparam logic MemWrite = 1'b1;

endpackage

// File: rtl/fetch_slot.sv
// One-entry output register with valid/ready handshake and flush.
module fetch_slot #(
    parameter int unsigned WordSize  = 32,
    parameter int unsigned AddrWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 flush,
    input  logic                 ready,
    input  logic [WordSize-1:0]  load_instr,
    input  logic [AddrWidth-1:0] load_pc,
    output logic                 valid,
    output logic [WordSize-1:0]  instr,
    output logic [AddrWidth-1:0] pc
);

    // Flush wins over load; an unloaded slot drains once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/full_adder64.sv
// Generic ripple-free adder with carry in/out; instantiated narrower than 64 bits where needed.
module full_adder64 #(
    parameter int unsigned Width = 64
) (
    input  logic [Width-1:0] x,
    input  logic [Width-1:0] y,
    input  logic             carry_in,
    output logic [Width-1:0] sum,
    output logic             carry_out
);

    assign {carry_out, sum} = {1'b0, x} + {1'b0, y} + {{Width{1'b0}}, carry_in};

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the Memory combinationally and feeds a one-entry output slot.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned          WordSize   = 32,
    parameter int unsigned          AddrWidth  = 8,
    parameter logic [AddrWidth-1:0] ResetPC    = '0,
    parameter logic [WordSize-1:0]  HaltWord   = WordSize'(DefaultHaltWord),
    parameter int unsigned          CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_status,
    output logic [AddrWidth-1:0]  mem_address,
    input  logic [WordSize-1:0]   mem_q,
    input  logic                  redirect,
    input  logic [AddrWidth-1:0]  redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WordSize-1:0]   out_instr,
    output logic [AddrWidth-1:0]  out_pc,
    output logic                  halted,
    output logic [CountWidth-1:0] fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [AddrWidth-1:0]  pc_q, pc_d, pc_inc;
    logic [CountWidth-1:0] fetch_count_q;
    logic                  pc_carry_unused;
    logic                  slot_free, handshake, load, flush;

    assign slot_free   = !out_valid || out_ready;
    assign handshake   = out_valid && out_ready;
    assign mem_address = pc_q;
    assign mem_status  = MemRead;
    assign halted      = (state_q == StHalt);
    assign fetch_count = fetch_count_q;

    full_adder64 #(
        .Width (AddrWidth)
    ) u_pc_adder (
        .x         (pc_q),
        .y         (AddrWidth'(1)),
        .carry_in  (1'b0),
        .sum       (pc_inc),
        .carry_out (pc_carry_unused)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = StFetch;
            flush   = 1'b1;
        end else if (state_q == StFetch && slot_free) begin
            // The terminator is never loaded; a free slot simply drains.
            if (mem_q != HaltWord) begin
                load = 1'b1;
                pc_d = pc_inc;
            end else begin
                state_d = StHalt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            pc_q          <= ResetPC;
            fetch_count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (handshake) begin
                fetch_count_q <= fetch_count_q + 1'b1;
            end
        end
    end

    fetch_slot #(
        .WordSize  (WordSize),
        .AddrWidth (AddrWidth)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .ready      (out_ready),
        .load_instr (mem_q),
        .load_pc    (pc_q),
        .valid      (out_valid),
        .instr      (out_instr),
        .pc         (out_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plan checks plus randomized redirect/backpressure against an address-walk reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_status;
    logic [7:0]  mem_address;
    logic [31:0] mem_q;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [256];
    assign mem_q = mem[mem_address];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_status  (mem_status),
        .mem_address (mem_address),
        .mem_q       (mem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the words a consumer should see are the memory walk from the
    // last restart address up to (not including) the terminator.
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] w;
    } ent_t;

    ent_t        exp_q[$];
    int          exp_cnt;
    logic        stall_pend;
    logic [31:0] held_instr;
    logic [7:0]  held_pc;

    task automatic rebuild(input logic [7:0] start);
        logic [7:0] a;
        exp_q.delete();
        a = start;
        for (int n = 0; n < 256; n++) begin
            if (mem[a] == 32'd0) break;
            exp_q.push_back('{pc: a, w: mem[a]});
            a = a + 8'd1;
        end
    endtask

    task automatic model_cycle();
        ent_t e;
        @(negedge clk);
        if (stall_pend) begin
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_instr", 64'(out_instr), 64'(held_instr));
            check_eq("stall_pc", 64'(out_pc), 64'(held_pc));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rand_instr", 64'(out_instr), 64'(e.w));
                check_eq("rand_pc", 64'(out_pc), 64'(e.pc));
            end
            exp_cnt++;
        end
        stall_pend = out_valid && !out_ready && !redirect;
        held_instr = out_instr;
        held_pc    = out_pc;
        if (redirect) rebuild(redirect_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int unsigned seq [7] = '{4, 1, 3, 4, 2, 5, 6};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 7; i++) mem[i] = seq[i];
        mem[255] = 32'hAB;

        // Reset state and straight-line run to the terminator.
        #2;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_count", 64'(fetch_count), 64'd0);
        check_eq("mem_status", 64'(mem_status), 64'd0);
        do_reset();
        out_ready = 1'b1;
        check_eq("rel_addr", 64'(mem_address), 64'd0);
        for (int i = 0; i < 7; i++) begin
            cyc();
            check_eq("seq_instr", 64'(out_instr), 64'(seq[i]));
            check_eq("seq_pc", 64'(out_pc), 64'(i));
        end
        cyc();
        check_eq("halt_valid", 64'(out_valid), 64'd0);
        check_eq("halt_flag", 64'(halted), 64'd1);
        check_eq("halt_addr", 64'(mem_address), 64'd7);
        check_eq("halt_count", 64'(fetch_count), 64'd7);

        // Backpressure after the first word.
        do_reset();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("bp_instr", 64'(out_instr), 64'd4);
            check_eq("bp_pc", 64'(out_pc), 64'd0);
            check_eq("bp_addr", 64'(mem_address), 64'd1);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 7; i++) begin
            cyc();
            check_eq("bp_seq_instr", 64'(out_instr), 64'(seq[i]));
            check_eq("bp_seq_pc", 64'(out_pc), 64'(i));
        end
        cyc();
        check_eq("bp_halt", 64'(halted), 64'd1);
        check_eq("bp_count", 64'(fetch_count), 64'd7);

        // Redirect out of HALT.
        redirect    = 1'b1;
        redirect_pc = 8'd5;
        cyc();
        redirect = 1'b0;
        check_eq("rd_halted", 64'(halted), 64'd0);
        check_eq("rd_valid", 64'(out_valid), 64'd0);
        check_eq("rd_addr", 64'(mem_address), 64'd5);
        cyc();
        check_eq("rd_instr5", 64'(out_instr), 64'd5);
        check_eq("rd_pc5", 64'(out_pc), 64'd5);
        cyc();
        check_eq("rd_instr6", 64'(out_instr), 64'd6);
        cyc();
        check_eq("rd_rehalt", 64'(halted), 64'd1);
        check_eq("rd_rehalt_valid", 64'(out_valid), 64'd0);

        // Redirect coinciding with a handshake.
        do_reset();
        cyc();
        cyc();
        check_eq("rh_pc1", 64'(out_pc), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 8'd3;
        cyc();
        redirect = 1'b0;
        check_eq("rh_count", 64'(fetch_count), 64'd2);
        check_eq("rh_bubble", 64'(out_valid), 64'd0);
        cyc();
        check_eq("rh_instr", 64'(out_instr), 64'd4);
        check_eq("rh_pc", 64'(out_pc), 64'd3);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        check_eq("mr_pre_valid", 64'(out_valid), 64'd1);
        check_eq("mr_pre_addr", 64'(mem_address), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", 64'(out_valid), 64'd0);
        check_eq("mr_instr", 64'(out_instr), 64'd0);
        check_eq("mr_pc", 64'(out_pc), 64'd0);
        check_eq("mr_addr", 64'(mem_address), 64'd0);
        check_eq("mr_count", 64'(fetch_count), 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_eq("mr_restart_instr", 64'(out_instr), 64'd4);
        check_eq("mr_restart_pc", 64'(out_pc), 64'd0);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        cyc();
        redirect = 1'b0;
        cyc();
        check_eq("wrap_instr", 64'(out_instr), 64'hAB);
        check_eq("wrap_pc", 64'(out_pc), 64'hFF);
        cyc();
        check_eq("wrap_next_pc", 64'(out_pc), 64'd0);
        check_eq("wrap_next_instr", 64'(out_instr), 64'd4);

        // Randomized memory, backpressure and redirects.
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
        mem[$urandom_range(0, 255)] = 32'd0;
        do_reset();
        rebuild(8'd0);
        exp_cnt    = 0;
        stall_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 40) == 0);
            redirect_pc = 8'($urandom);
            model_cycle();
        end
        redirect  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (halted && !out_valid) break;
            model_cycle();
        end
        check_eq("rand_halted", 64'(halted), 64'd1);
        check_eq("rand_leftover", 64'(exp_q.size()), 64'd0);
        check_eq("rand_count", 64'(fetch_count), 64'(exp_cnt[15:0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
